// File: rtl/mem_pkg.sv
// mem_pkg: shared types and widths for the SDRAM arbiter slice
package mem_pkg;
  localparam int MEM_AW = 22;
  localparam int MEM_DW = 16;
  localparam int PEND_MAX = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic [1:0] {OWN_REF, OWN_A, OWN_B} owner_t;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: one client port (request, write data, ack and read return)
interface sdram_port_arbiter_if;
  import mem_pkg::*;
  logic req;
  logic we;
  logic [MEM_AW-1:0] addr;
  logic [MEM_DW-1:0] din;
  logic [1:0] wdm;
  logic ack;
  logic rvalid;
  logic [MEM_DW-1:0] dout;
  modport master(output req, we, addr, din, wdm, input ack, rvalid, dout);
  modport slave(input req, we, addr, din, wdm, output ack, rvalid, dout);
endinterface

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: periodic refresh ticks with a saturating backlog of pending refreshes
module sdram_refresh_timer
  import mem_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 810
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       issue,
  output logic [2:0] pending,
  output logic       overdue
);
  localparam int CW = $clog2(REFRESH_INTERVAL + 1);
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = en && cnt == '0;
  assign overdue = pending >= 3'd2;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= CW'(REFRESH_INTERVAL - 1);
      pending <= '0;
    end else begin
      if (en) cnt <= tick ? CW'(REFRESH_INTERVAL - 1) : cnt - 1'b1;
      pending <= (tick && !issue && pending != 3'(PEND_MAX)) ? pending + 1'b1 :
                 (issue && !tick) ? pending - 1'b1 : pending;
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: merges two client ports and auto-refresh onto the controller strobe interface
module sdram_port_arbiter
  import mem_pkg::*;
#(
  parameter int FREQ = 54_000_000,
  parameter int REFRESH_INTERVAL = 810,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  sdram_port_arbiter_if.slave port_a,
  sdram_port_arbiter_if.slave port_b,
  output logic              mc_read,
  output logic              mc_write,
  output logic              mc_refresh,
  output logic [MEM_AW-1:0] mc_addr,
  output logic [MEM_DW-1:0] mc_din,
  output logic [1:0]        mc_wdm,
  input  logic [MEM_DW-1:0] mc_dout,
  input  logic              mc_busy,
  output logic              refresh_overdue
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  if (FREQ <= 0) begin : g_bad_freq
    $error("FREQ must be positive");
  end
  state_t state;
  owner_t owner;
  logic rd, init_done;
  logic [SW-1:0] starve;
  logic [2:0] pending;
  logic idle_go, force_b, grant_ref, grant_a, grant_b, grant_rd, grant_wr;
  // refresh beats the starvation override, which beats port A
  assign idle_go = state == ST_IDLE && init_done && !mc_busy;
  assign force_b = port_b.req && starve == SW'(STARVE_LIMIT);
  assign grant_ref = idle_go && pending != '0;
  assign grant_a = idle_go && pending == '0 && !force_b && port_a.req;
  assign grant_b = idle_go && pending == '0 && (force_b || !port_a.req) && port_b.req;
  assign grant_rd = (grant_a && !port_a.we) || (grant_b && !port_b.we);
  assign grant_wr = (grant_a && port_a.we) || (grant_b && port_b.we);
  sdram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_timer (
    .clk(clk),
    .resetn(resetn),
    .en(init_done),
    .issue(grant_ref),
    .pending(pending),
    .overdue(refresh_overdue)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      owner <= OWN_REF;
      rd <= 1'b0;
      init_done <= 1'b0;
      starve <= '0;
      mc_read <= 1'b0;
      mc_write <= 1'b0;
      mc_refresh <= 1'b0;
      mc_addr <= '0;
      mc_din <= '0;
      mc_wdm <= '0;
      port_a.ack <= 1'b0;
      port_a.rvalid <= 1'b0;
      port_a.dout <= '0;
      port_b.ack <= 1'b0;
      port_b.rvalid <= 1'b0;
      port_b.dout <= '0;
    end else begin
      init_done <= init_done || !mc_busy;
      port_a.ack <= grant_a;
      port_b.ack <= grant_b;
      port_a.rvalid <= 1'b0;
      port_b.rvalid <= 1'b0;
      starve <= (!port_b.req || grant_b) ? '0 :
                (grant_a && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
      case (state)
        ST_IDLE: if (grant_ref || grant_a || grant_b) begin
          state <= ST_ISSUE;
          mc_refresh <= grant_ref;
          mc_read <= grant_rd;
          mc_write <= grant_wr;
          rd <= grant_rd;
          owner <= grant_ref ? OWN_REF : grant_a ? OWN_A : OWN_B;
          if (!grant_ref) begin
            mc_addr <= grant_a ? port_a.addr : port_b.addr;
            mc_din <= grant_a ? port_a.din : port_b.din;
            mc_wdm <= grant_a ? port_a.wdm : port_b.wdm;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
          mc_read <= 1'b0;
          mc_write <= 1'b0;
          mc_refresh <= 1'b0;
        end
        ST_WAIT: if (!mc_busy) begin
          state <= ST_IDLE;
          if (rd && owner == OWN_A) begin
            port_a.rvalid <= 1'b1;
            port_a.dout <= mc_dout;
          end
          if (rd && owner == OWN_B) begin
            port_b.rvalid <= 1'b1;
            port_b.dout <= mc_dout;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed and random stimulus against a controller model and a rule-level reference
module tb_sdram_port_arbiter;
  import mem_pkg::*;
  localparam int RI = 20;
  localparam int SL = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic init_hold = 1'b1;
  logic force_busy = 1'b0;
  sdram_port_arbiter_if pa();
  sdram_port_arbiter_if pb();
  logic mc_read, mc_write, mc_refresh, mc_busy, refresh_overdue;
  logic [MEM_AW-1:0] mc_addr;
  logic [MEM_DW-1:0] mc_din, mc_dout;
  logic [1:0] mc_wdm;
  always #5 clk = ~clk;
  sdram_port_arbiter #(.REFRESH_INTERVAL(RI), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .resetn(resetn), .port_a(pa), .port_b(pb),
    .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
    .mc_dout(mc_dout), .mc_busy(mc_busy), .refresh_overdue(refresh_overdue)
  );
  logic [15:0] mem [logic [21:0]];
  function automatic logic [15:0] rd_mem(logic [21:0] a);
    return mem.exists(a) ? mem[a] : a[15:0] ^ 16'h5A3C;
  endfunction
  // controller model: latches a strobe, stays busy four cycles, masks bytes whose wdm bit is set
  logic [2:0] ctl_cnt;
  assign mc_busy = init_hold || force_busy || ctl_cnt != 3'd0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctl_cnt <= 3'd0;
      mc_dout <= 16'h0;
    end else if (mc_read || mc_write || mc_refresh) begin
      ctl_cnt <= 3'd4;
      if (mc_read) mc_dout <= rd_mem(mc_addr);
      if (mc_write)
        mem[mc_addr] = {mc_wdm[1] ? rd_mem(mc_addr) >> 8 : {8'h0, mc_din[15:8]}, 8'h0} |
                       {8'h0, mc_wdm[0] ? rd_mem(mc_addr) & 16'h00FF : {8'h0, mc_din[7:0]}};
    end else if (ctl_cnt != 3'd0) ctl_cnt <= ctl_cnt - 3'd1;
  end
  // reference: decides each edge's winner from pending/starve/request rules, one op in flight
  bit m_init, m_fly, m_rd;
  int m_age, m_since, m_pend, m_starve, win;
  bit tk;
  owner_t m_own;
  logic [21:0] m_addr;
  logic e_a_ack = 0, e_b_ack = 0, e_a_rv = 0, e_b_rv = 0, e_rd = 0, e_wr = 0, e_rf = 0, e_ovd = 0;
  logic [15:0] e_a_dout = 0, e_b_dout = 0, e_din = 0;
  logic [21:0] e_addr = 0;
  logic [1:0] e_wdm = 0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_init = 0; m_fly = 0; m_rd = 0; m_age = 0; m_since = 0; m_pend = 0; m_starve = 0;
      m_own = OWN_REF; m_addr = 0;
      {e_a_ack, e_b_ack, e_a_rv, e_b_rv, e_rd, e_wr, e_rf, e_ovd} = 8'h0;
      e_a_dout = 0; e_b_dout = 0; e_din = 0; e_addr = 0; e_wdm = 0;
    end else begin
      win = 0;
      {e_a_ack, e_b_ack, e_a_rv, e_b_rv, e_rd, e_wr, e_rf} = 7'h0;
      if (m_fly) begin
        m_since++;
        if (m_since >= 2 && !mc_busy) begin
          m_fly = 0;
          if (m_rd && m_own == OWN_A) begin e_a_rv = 1; e_a_dout = rd_mem(m_addr); end
          if (m_rd && m_own == OWN_B) begin e_b_rv = 1; e_b_dout = rd_mem(m_addr); end
        end
      end else if (m_init && !mc_busy)
        win = m_pend > 0 ? 1 : (pb.req && m_starve == SL) ? 3 : pa.req ? 2 : pb.req ? 3 : 0;
      if (win == 1) begin e_rf = 1; m_rd = 0; m_own = OWN_REF; end
      if (win == 2) begin
        e_a_ack = 1; e_rd = !pa.we; e_wr = pa.we; m_rd = !pa.we; m_own = OWN_A;
        e_addr = pa.addr; e_din = pa.din; e_wdm = pa.wdm; m_addr = pa.addr;
      end
      if (win == 3) begin
        e_b_ack = 1; e_rd = !pb.we; e_wr = pb.we; m_rd = !pb.we; m_own = OWN_B;
        e_addr = pb.addr; e_din = pb.din; e_wdm = pb.wdm; m_addr = pb.addr;
      end
      if (win != 0) begin m_fly = 1; m_since = 0; end
      tk = 0;
      if (m_init) begin m_age++; tk = (m_age % RI) == 0; end
      if (tk && win != 1) m_pend = m_pend < 7 ? m_pend + 1 : 7;
      else if (!tk && win == 1) m_pend--;
      m_starve = (!pb.req || win == 3) ? 0 : (win == 2 && m_starve < SL) ? m_starve + 1 : m_starve;
      m_init = m_init || !mc_busy;
      e_ovd = m_pend >= 2;
    end
  end
  int checks = 0, passed = 0, cyc = 0;
  int n_a_ack = 0, n_b_ack = 0, n_a_rv = 0, n_b_rv = 0, n_rd = 0, n_strobe = 0, t_a_ack = 0;
  int t_ref[$];
  byte glog[$];
  bit auto_a = 0, auto_b = 0, rnd = 0, ok;
  function automatic logic [79:0] obs();
    return {pa.ack, pb.ack, pa.rvalid, pb.rvalid, pa.dout, pb.dout, mc_read, mc_write, mc_refresh,
            mc_addr, mc_din, mc_wdm, refresh_overdue};
  endfunction
  function automatic logic [79:0] expv();
    return {e_a_ack, e_b_ack, e_a_rv, e_b_rv, e_a_dout, e_b_dout, e_rd, e_wr, e_rf,
            e_addr, e_din, e_wdm, e_ovd};
  endfunction
  task automatic chk(string tag, logic [79:0] got, logic [79:0] want);
    checks++;
    assert (got === want) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
  endtask
  task automatic new_a();
    pa.req = 1; pa.we = 1'($urandom_range(1)); pa.addr = 22'($urandom_range(63));
    pa.din = 16'($urandom); pa.wdm = 2'($urandom);
  endtask
  task automatic new_b();
    pb.req = 1; pb.we = 1'($urandom_range(1)); pb.addr = 22'($urandom_range(63));
    pb.din = 16'($urandom); pb.wdm = 2'($urandom);
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("cycle_outputs", obs(), expv());
    if (mc_refresh) begin glog.push_back("R"); t_ref.push_back(cyc); end
    if (mc_read) n_rd++;
    if (mc_read || mc_write || mc_refresh) n_strobe++;
    if (pa.rvalid) n_a_rv++;
    if (pb.rvalid) n_b_rv++;
    if (pa.ack) begin
      n_a_ack++; t_a_ack = cyc; glog.push_back("A");
      if (auto_a) new_a(); else pa.req = 0;
    end
    if (pb.ack) begin
      n_b_ack++; glog.push_back("B");
      if (auto_b) new_b(); else pb.req = 0;
    end
    if (rnd && !pa.ack && $urandom_range(23) == 0) begin if (pa.req) pa.req = 0; else new_a(); end
    if (rnd && !pb.ack && $urandom_range(23) == 0) begin if (pb.req) pb.req = 0; else new_b(); end
    if (rnd && $urandom_range(40) == 0) force_busy = !force_busy;
  endtask
  initial begin
    int m0, m1, k;
    logic [9:0] order;
    pa.req = 0; pa.we = 0; pa.addr = 0; pa.din = 0; pa.wdm = 0;
    pb.req = 0; pb.we = 0; pb.addr = 0; pb.din = 0; pb.wdm = 0;
    repeat (3) tick();
    chk("reset_state", obs(), 80'h0);
    resetn = 1;
    pa.we = 0; pa.addr = 22'h000010; pa.req = 1;
    repeat (100) tick();
    chk("init_no_ack", 80'(n_a_ack), 80'h0);
    chk("init_no_strobe", 80'(n_strobe), 80'h0);
    init_hold = 0;
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin tick(); ok = pa.ack; end
    chk("init_ack", 80'(ok), 80'h1);
    repeat (10) tick();
    chk("init_read_once", 80'(n_rd), 80'h1);
    mem[22'h012345] = 16'hBEEF;
    m0 = n_b_rv;
    pa.we = 0; pa.addr = 22'h012345; pa.req = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = pa.ack; end
    chk("a_ack_seen", 80'(ok), 80'h1);
    m1 = t_a_ack;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = pa.rvalid; end
    chk("a_rvalid_seen", 80'(ok), 80'h1);
    chk("a_rvalid_latency", 80'(cyc - m1), 80'd6);
    chk("a_dout", 80'(pa.dout), 80'hBEEF);
    repeat (5) tick();
    chk("b_rvalid_quiet", 80'(n_b_rv - m0), 80'h0);
    m0 = n_a_rv + n_b_rv; m1 = n_b_ack;
    pb.we = 1; pb.addr = 22'h000777; pb.din = 16'h55AA; pb.wdm = 2'b01; pb.req = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = pb.ack; end
    chk("b_ack_seen", 80'(ok), 80'h1);
    chk("b_write_strobe", 80'({mc_write, mc_read, mc_din, mc_wdm}), 80'({1'b1, 1'b0, 16'h55AA, 2'b01}));
    repeat (10) tick();
    chk("b_ack_once", 80'(n_b_ack - m1), 80'h1);
    chk("b_no_rvalid", 80'(n_a_rv + n_b_rv - m0), 80'h0);
    m0 = glog.size(); m1 = n_a_ack + n_b_ack;
    auto_a = 1; auto_b = 1; new_a(); new_b();
    for (int i = 0; i < 400 && n_a_ack + n_b_ack - m1 < 10; i++) tick();
    auto_a = 0; auto_b = 0; pa.req = 0; pb.req = 0;
    order = '1; k = 0;
    for (int i = m0; i < glog.size() && k < 10; i++)
      if (glog[i] != "R") begin order[9 - k] = glog[i] == "B"; k++; end
    chk("starve_order", 80'(order), 80'(10'b0000100001));
    repeat (30) tick();
    m0 = t_ref.size();
    for (int i = 0; i < 100 && t_ref.size() < m0 + 3; i++) tick();
    chk("refresh_gap1", 80'(t_ref.size() >= m0 + 3 ? t_ref[m0 + 1] - t_ref[m0] : 0), 80'd20);
    chk("refresh_gap2", 80'(t_ref.size() >= m0 + 3 ? t_ref[m0 + 2] - t_ref[m0 + 1] : 0), 80'd20);
    force_busy = 1;
    pa.we = 0; pa.addr = 22'h000021; pa.req = 1;
    repeat (45) tick();
    chk("refresh_overdue", 80'(refresh_overdue), 80'h1);
    force_busy = 0;
    m0 = glog.size(); m1 = t_ref.size();
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = pa.ack; end
    chk("overdue_a_served", 80'(ok), 80'h1);
    chk("refresh_first_two", 80'(glog.size() > m0 + 1 && glog[m0] == "R" && glog[m0 + 1] == "R"), 80'h1);
    chk("refresh_back_to_back", 80'(t_ref.size() > m1 + 1 ? t_ref[m1 + 1] - t_ref[m1] : 0), 80'd7);
    repeat (10) tick();
    rnd = 1; auto_a = 1; auto_b = 1;
    repeat (1500) tick();
    rnd = 0; auto_a = 0; auto_b = 0; pa.req = 0; pb.req = 0; force_busy = 0;
    repeat (20) tick();
    pa.we = 0; pa.addr = 22'h000005; pa.req = 1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = pa.ack; end
    chk("midop_ack", 80'(ok), 80'h1);
    repeat (3) tick();
    #2 resetn = 0; init_hold = 1;
    #1 chk("reset_async", obs(), 80'h0);
    pa.req = 1;
    repeat (3) tick();
    resetn = 1;
    m0 = n_a_rv; m1 = n_a_ack;
    repeat (20) tick();
    chk("reset_no_rvalid", 80'(n_a_rv - m0), 80'h0);
    chk("reset_no_ack", 80'(n_a_ack - m1), 80'h0);
    init_hold = 0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = pa.ack; end
    chk("reinit_ack", 80'(ok), 80'h1);
    repeat (10) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
